// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one synchronous memory read port (one-cycle read latency) between an
// instruction-fetch requester (port A) and a data-load requester (port B).
// Accesses are serialised IDLE -> ISSUE -> WAIT -> IDLE with round-robin
// fairness on ties. Each response (data + error) is returned to the granted
// port together with a one-cycle ack pulse.
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   a_req / b_req       : request, held high until ack
//   a_addr, a_extra,
//   a_lower, a_upper    : port A request fields (B likewise)
//   a_ack / b_ack       : one-cycle response pulse
//   a_data, a_error     : port A response, held until A's next ack (B likewise)
//   mem_addr, mem_extra,
//   mem_lower, mem_upper: registered memory request
//   mem_data, mem_error : memory response, valid one cycle after addr sampled
//   busy                : access in flight
//   grant               : owner of current/last access (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_DEPTH = 3,
    parameter int MEM_EXTRA = 4,
    localparam int DW = (2 ** MEM_EXTRA) * 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic [MEM_DEPTH:0]   a_addr,
    input  logic [MEM_EXTRA-1:0] a_extra,
    input  logic [MEM_DEPTH:0]   a_lower,
    input  logic [MEM_DEPTH:0]   a_upper,
    input  logic                 b_req,
    input  logic [MEM_DEPTH:0]   b_addr,
    input  logic [MEM_EXTRA-1:0] b_extra,
    input  logic [MEM_DEPTH:0]   b_lower,
    input  logic [MEM_DEPTH:0]   b_upper,
    output logic                 a_ack,
    output logic [DW-1:0]        a_data,
    output logic                 a_error,
    output logic                 b_ack,
    output logic [DW-1:0]        b_data,
    output logic                 b_error,
    output logic [MEM_DEPTH:0]   mem_addr,
    output logic [MEM_EXTRA-1:0] mem_extra,
    output logic [MEM_DEPTH:0]   mem_lower,
    output logic [MEM_DEPTH:0]   mem_upper,
    input  logic [DW-1:0]        mem_data,
    input  logic                 mem_error,
    output logic                 busy,
    output logic                 grant
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]           r_state;
    logic                 r_last;
    logic                 r_grant;
    logic                 r_busy;
    logic                 r_a_ack;
    logic                 r_b_ack;
    logic [DW-1:0]        r_a_data;
    logic                 r_a_error;
    logic [DW-1:0]        r_b_data;
    logic                 r_b_error;
    logic [MEM_DEPTH:0]   r_mem_addr;
    logic [MEM_EXTRA-1:0] r_mem_extra;
    logic [MEM_DEPTH:0]   r_mem_lower;
    logic [MEM_DEPTH:0]   r_mem_upper;

    logic                 w_a_qual;
    logic                 w_b_qual;
    logic                 w_win_b;
    logic                 w_do_grant;
    logic                 w_do_done;
    logic [1:0]           w_state_nxt;
    logic [MEM_DEPTH:0]   w_sel_addr;
    logic [MEM_EXTRA-1:0] w_sel_extra;
    logic [MEM_DEPTH:0]   w_sel_lower;
    logic [MEM_DEPTH:0]   w_sel_upper;

    // A port whose ack is high this cycle has just been served; masking it
    // stops the still-high req from being issued a second time.
    assign w_a_qual   = a_req & ~r_a_ack;
    assign w_b_qual   = b_req & ~r_b_ack;
    // B wins when it is alone, or on a tie when A was served last.
    assign w_win_b    = w_b_qual & (~w_a_qual | ~r_last);
    assign w_do_grant = (r_state == IDLE) & (w_a_qual | w_b_qual);
    assign w_do_done  = (r_state == WAIT);

    // Next-state selection for the access sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_a_qual | w_b_qual) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request-field mux picking the winning port's fields.
    always_comb begin
        w_sel_addr  = a_addr;
        w_sel_extra = a_extra;
        w_sel_lower = a_lower;
        w_sel_upper = a_upper;
        if (w_win_b) begin
            w_sel_addr  = b_addr;
            w_sel_extra = b_extra;
            w_sel_lower = b_lower;
            w_sel_upper = b_upper;
        end else begin
            w_sel_addr  = a_addr;
            w_sel_extra = a_extra;
            w_sel_lower = a_lower;
            w_sel_upper = a_upper;
        end
    end

    // Sequencer state, ownership tracking and busy flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_do_grant) begin
                r_grant <= w_win_b;
                r_last  <= w_win_b;
            end
        end
    end

    // Memory request registers; they change only on a grant and hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_addr  <= {(MEM_DEPTH+1){1'b0}};
            r_mem_extra <= {MEM_EXTRA{1'b0}};
            r_mem_lower <= {(MEM_DEPTH+1){1'b0}};
            r_mem_upper <= {(MEM_DEPTH+1){1'b0}};
        end else if (w_do_grant) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_extra <= w_sel_extra;
            r_mem_lower <= w_sel_lower;
            r_mem_upper <= w_sel_upper;
        end
    end

    // Response capture into the granted port and its one-cycle ack pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_data  <= {DW{1'b0}};
            r_a_error <= 1'b0;
            r_b_data  <= {DW{1'b0}};
            r_b_error <= 1'b0;
        end else begin
            r_a_ack <= w_do_done & ~r_grant;
            r_b_ack <= w_do_done &  r_grant;
            if (w_do_done && r_grant) begin
                r_b_data  <= mem_data;
                r_b_error <= mem_error;
            end else if (w_do_done) begin
                r_a_data  <= mem_data;
                r_a_error <= mem_error;
            end
        end
    end

    assign a_ack     = r_a_ack;
    assign b_ack     = r_b_ack;
    assign a_data    = r_a_data;
    assign a_error   = r_a_error;
    assign b_data    = r_b_data;
    assign b_error   = r_b_error;
    assign mem_addr  = r_mem_addr;
    assign mem_extra = r_mem_extra;
    assign mem_lower = r_mem_lower;
    assign mem_upper = r_mem_upper;
    assign busy      = r_busy;
    assign grant     = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (grant timestamp + fixed completion delay, memory behaviour
// derived from the latched request) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int DW = 128;

    logic         clk;
    logic         reset;
    logic         a_req, b_req;
    logic [3:0]   a_addr, a_lower, a_upper, b_addr, b_lower, b_upper;
    logic [3:0]   a_extra, b_extra;
    logic         a_ack, b_ack, a_error, b_error, busy, grant;
    logic [DW-1:0] a_data, b_data;
    logic [3:0]   mem_addr, mem_extra, mem_lower, mem_upper;
    logic [DW-1:0] tb_mem_data = '0;
    logic         tb_mem_error = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int           cyc = 0;
    bit           m_inflight;
    int           m_due;
    bit           m_last, m_grant, m_a_ack, m_b_ack, m_a_err, m_b_err;
    logic [DW-1:0] m_a_data, m_b_data;
    logic [3:0]   m_addr, m_extra, m_lower, m_upper;

    mem_arbiter #(.MEM_DEPTH(3), .MEM_EXTRA(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_extra(a_extra), .a_lower(a_lower), .a_upper(a_upper),
        .b_req(b_req), .b_addr(b_addr), .b_extra(b_extra), .b_lower(b_lower), .b_upper(b_upper),
        .a_ack(a_ack), .a_data(a_data), .a_error(a_error),
        .b_ack(b_ack), .b_data(b_data), .b_error(b_error),
        .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_lower(mem_lower), .mem_upper(mem_upper),
        .mem_data(tb_mem_data), .mem_error(tb_mem_error),
        .busy(busy), .grant(grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory: returns the address byte replicated, error when out of bounds
    always @(posedge clk) begin
        tb_mem_data  <= {16{{4'h0, mem_addr}}};
        tb_mem_error <= (mem_addr < mem_lower) || (mem_addr > mem_upper);
    end

    function automatic logic [DW-1:0] exp_word(input logic [3:0] a);
        return {16{{4'h0, a}}};
    endfunction

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // advance the model by one clock edge using the inputs seen at that edge
    task automatic model_step();
        bit qa, qb, g, oob;
        cyc++;
        if (!reset) begin
            m_inflight = 1'b0;
            m_last = 1'b1; m_grant = 1'b0;
            m_a_ack = 1'b0; m_b_ack = 1'b0;
            m_a_err = 1'b0; m_b_err = 1'b0;
            m_a_data = '0;  m_b_data = '0;
            m_addr = '0; m_extra = '0; m_lower = '0; m_upper = '0;
        end else begin
            qa = a_req && !m_a_ack;
            qb = b_req && !m_b_ack;
            m_a_ack = 1'b0;
            m_b_ack = 1'b0;
            if (m_inflight && cyc == m_due) begin
                m_inflight = 1'b0;
                oob = (m_addr < m_lower) || (m_addr > m_upper);
                if (m_grant) begin
                    m_b_ack = 1'b1; m_b_data = exp_word(m_addr); m_b_err = oob;
                end else begin
                    m_a_ack = 1'b1; m_a_data = exp_word(m_addr); m_a_err = oob;
                end
            end else if (!m_inflight && (qa || qb)) begin
                g = (qa && qb) ? !m_last : qb;
                m_grant = g;
                m_last  = g;
                m_addr  = g ? b_addr  : a_addr;
                m_extra = g ? b_extra : a_extra;
                m_lower = g ? b_lower : a_lower;
                m_upper = g ? b_upper : a_upper;
                m_inflight = 1'b1;
                m_due = cyc + 2;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("a_ack",     a_ack,     m_a_ack);
        check_eq("b_ack",     b_ack,     m_b_ack);
        check_eq("a_data",    a_data,    m_a_data);
        check_eq("a_error",   a_error,   m_a_err);
        check_eq("b_data",    b_data,    m_b_data);
        check_eq("b_error",   b_error,   m_b_err);
        check_eq("mem_addr",  mem_addr,  m_addr);
        check_eq("mem_extra", mem_extra, m_extra);
        check_eq("mem_lower", mem_lower, m_lower);
        check_eq("mem_upper", mem_upper, m_upper);
        check_eq("busy",      busy,      m_inflight);
        check_eq("grant",     grant,     m_grant);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    int ord_q[$];
    int cnt;
    bit seen;

    initial begin
        reset = 1'b0;
        a_req = 1'b1; a_addr = 4'd5; a_extra = 4'd3; a_lower = 4'd0; a_upper = 4'd15;
        b_req = 1'b1; b_addr = 4'd2; b_extra = 4'd1; b_lower = 4'd0; b_upper = 4'd15;
        #2;

        // reset with both requests high
        step(); step();
        check_eq("rst_acks", {a_ack, b_ack}, 2'b00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 4'd0);

        // single A access
        reset = 1'b1; b_req = 1'b0;
        step();
        check_eq("single_grant", grant, 1'b0);
        check_eq("single_mem_addr", mem_addr, 4'd5);
        check_eq("single_mem_extra", mem_extra, 4'd3);
        step();
        check_eq("single_ack_early", a_ack, 1'b0);
        step();
        check_eq("single_ack", a_ack, 1'b1);
        check_eq("single_data", a_data, exp_word(4'd5));
        check_eq("single_err", a_error, 1'b0);
        check_eq("single_b_ack", b_ack, 1'b0);
        a_req = 1'b0;
        step();
        check_eq("single_ack_pulse", a_ack, 1'b0);

        // contention after reset: A first, then alternate
        reset = 1'b0; step(); reset = 1'b1;
        a_addr = 4'd1; b_addr = 4'd2; a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (a_ack) ord_q.push_back(0);
            if (b_ack) ord_q.push_back(1);
        end
        check_eq("cont_count_ge4", (ord_q.size() >= 4), 1'b1);
        for (int i = 0; i < 4 && i < ord_q.size(); i++)
            check_eq("cont_order", ord_q[i], i % 2);
        check_eq("cont_a_data", a_data, exp_word(4'd1));
        check_eq("cont_b_data", b_data, exp_word(4'd2));
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) step();

        // error path on B; A's response registers untouched
        b_lower = 4'd4; b_upper = 4'd6; b_addr = 4'd7; b_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (b_ack) seen = 1'b1;
        end
        check_eq("err_b_ack_seen", seen, 1'b1);
        check_eq("err_b_error", b_error, 1'b1);
        check_eq("err_a_error", a_error, 1'b0);
        check_eq("err_a_data", a_data, exp_word(4'd1));
        b_req = 1'b0;
        repeat (2) step();

        // withdrawn request: one cycle of req still completes exactly once
        a_addr = 4'd9; a_req = 1'b1;
        step();
        a_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_ack) cnt++;
        end
        check_eq("withdraw_acks", cnt, 1);
        check_eq("withdraw_data", a_data, exp_word(4'd9));

        // reset during WAIT aborts the access
        a_addr = 4'd3; a_req = 1'b1;
        step(); step();
        a_req = 1'b0; reset = 1'b0;
        step();
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_a_data", a_data, {DW{1'b0}});
        check_eq("abort_ack", a_ack, 1'b0);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_ack || b_ack) cnt++;
        end
        check_eq("abort_no_late_ack", cnt, 0);
        a_addr = 4'd6; a_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (a_ack) seen = 1'b1;
        end
        check_eq("post_abort_ack_seen", seen, 1'b1);
        check_eq("post_abort_data", a_data, exp_word(4'd6));
        a_req = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            reset = ($urandom_range(0, 199) != 0);
            if (a_req && m_a_ack) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_addr = 4'($urandom); a_extra = 4'($urandom);
                a_lower = 4'($urandom); a_upper = 4'($urandom);
            end else if (!a_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    a_req = 1'b1;
                    a_addr = 4'($urandom); a_extra = 4'($urandom);
                    a_lower = 4'($urandom); a_upper = 4'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                a_req = 1'b0;
            end
            if (b_req && m_b_ack) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_addr = 4'($urandom); b_extra = 4'($urandom);
                b_lower = 4'($urandom); b_upper = 4'($urandom);
            end else if (!b_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    b_req = 1'b1;
                    b_addr = 4'($urandom); b_extra = 4'($urandom);
                    b_lower = 4'($urandom); b_upper = 4'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                b_req = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
